// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter letting two valid/ready masters share one single-port RAM
// with a bidirectional data bus; every read is followed by a bus-turnaround gap.
module ram_port_arbiter #(
    parameter int         ADDR_W   = 5,
    parameter int         DATA_W   = 8,
    parameter int         TURN_CYC = 1,
    parameter logic [1:0] IDLE_SEL = 2'b11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    inout  wire  [DATA_W-1:0] ram_io,
    output logic              ram_rd_wr,
    output logic [1:0]        ram_s,
    output logic [ADDR_W-1:0] ram_address,
    input  logic              ram_en
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR0  = 3'd1,
        ST_WR1  = 3'd2,
        ST_RD0  = 3'd3,
        ST_RD1  = 3'd4,
        ST_TURN = 3'd5
    } state_t;

    localparam int            TC_W    = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(TURN_CYC - 1);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TC_W-1:0]     turn_cnt_q, turn_cnt_d;
    logic [1:0]          ram_s_q, ram_s_d;
    logic                ram_rd_wr_q, ram_rd_wr_d;
    logic [ADDR_W-1:0]   ram_address_q, ram_address_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                bus_conflict_q, bus_conflict_d;
    logic                grant0_s, grant1_s, io_oe_s, bus_sel_s;

    // Round-robin grant: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        grant0_s   = req0_valid && (!req1_valid || last_grant_q);
        grant1_s   = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = (state_q == ST_IDLE) && grant0_s;
        req1_ready = (state_q == ST_IDLE) && grant1_s;
    end

    // Write data goes on the bus only while the RAM itself has released it.
    assign io_oe_s = ((state_q == ST_WR0) || (state_q == ST_WR1)) && !ram_en;
    assign ram_io  = io_oe_s ? wdata_q : {DATA_W{1'bz}};

    // Next-state, request latching, read capture and registered RAM pin values.
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        owner_d        = owner_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        turn_cnt_d     = turn_cnt_q;
        rvalid0_d      = 1'b0;
        rvalid1_d      = 1'b0;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        bus_conflict_d = bus_conflict_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_ready) begin
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    addr_d       = req0_addr;
                    wdata_d      = req0_wdata;
                    state_d      = req0_wr ? ST_WR0 : ST_RD0;
                end else if (req1_ready) begin
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    addr_d       = req1_addr;
                    wdata_d      = req1_wdata;
                    state_d      = req1_wr ? ST_WR0 : ST_RD0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR0: state_d = ST_WR1;
            ST_WR1: begin
                state_d = ST_IDLE;
                if (ram_en) begin
                    bus_conflict_d = 1'b1;
                end else begin
                    bus_conflict_d = bus_conflict_q;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                state_d    = ST_TURN;
                turn_cnt_d = {TC_W{1'b0}};
                if (owner_q) begin
                    rdata1_d  = ram_io;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = ram_io;
                    rvalid0_d = 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q == TC_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q + TC_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin values are computed from the next state so they line up with it after the edge.
        bus_sel_s     = (state_d == ST_WR0) || (state_d == ST_WR1) ||
                        (state_d == ST_RD0) || (state_d == ST_RD1);
        ram_s_d       = bus_sel_s ? 2'b00 : IDLE_SEL;
        ram_rd_wr_d   = !((state_d == ST_WR0) || (state_d == ST_WR1));
        ram_address_d = addr_d;
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            addr_q         <= {ADDR_W{1'b0}};
            wdata_q        <= {DATA_W{1'b0}};
            turn_cnt_q     <= {TC_W{1'b0}};
            ram_s_q        <= IDLE_SEL;
            ram_rd_wr_q    <= 1'b1;
            ram_address_q  <= {ADDR_W{1'b0}};
            rvalid0_q      <= 1'b0;
            rvalid1_q      <= 1'b0;
            rdata0_q       <= {DATA_W{1'b0}};
            rdata1_q       <= {DATA_W{1'b0}};
            bus_conflict_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            owner_q        <= owner_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            turn_cnt_q     <= turn_cnt_d;
            ram_s_q        <= ram_s_d;
            ram_rd_wr_q    <= ram_rd_wr_d;
            ram_address_q  <= ram_address_d;
            rvalid0_q      <= rvalid0_d;
            rvalid1_q      <= rvalid1_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
            bus_conflict_q <= bus_conflict_d;
        end
    end

    assign ram_s       = ram_s_q;
    assign ram_rd_wr   = ram_rd_wr_q;
    assign ram_address = ram_address_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a behavioural 32x8 RAM on the shared bus,
// one instance with TURN_CYC=1 and one with TURN_CYC=3.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, preload, force_en;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    logic       r0_valid, r0_wr, r0_ready, r0_rvalid;
    logic [4:0] r0_addr;
    logic [7:0] r0_wdata, r0_rdata;
    logic       r1_valid, r1_wr, r1_ready, r1_rvalid;
    logic [4:0] r1_addr;
    logic [7:0] r1_wdata, r1_rdata;
    wire  [7:0] ram_io;
    logic       ram_rd_wr, ram_en, ram_drive;
    logic [1:0] ram_s;
    logic [4:0] ram_address;
    logic [7:0] mem [0:31];

    logic       v3, rdy3, rv3, rd_wr3, en3, drive3;
    logic [4:0] a3, addr3;
    logic [7:0] rdata3, n_rdata3;
    logic       n_ready3, n_rvalid3;
    logic [1:0] s3;
    wire  [7:0] io3;
    logic [7:0] mem3 [0:31];

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_valid), .req0_wr(r0_wr), .req0_addr(r0_addr), .req0_wdata(r0_wdata),
        .req0_ready(r0_ready), .req0_rvalid(r0_rvalid), .req0_rdata(r0_rdata),
        .req1_valid(r1_valid), .req1_wr(r1_wr), .req1_addr(r1_addr), .req1_wdata(r1_wdata),
        .req1_ready(r1_ready), .req1_rvalid(r1_rvalid), .req1_rdata(r1_rdata),
        .ram_io(ram_io), .ram_rd_wr(ram_rd_wr), .ram_s(ram_s),
        .ram_address(ram_address), .ram_en(ram_en)
    );

    ram_port_arbiter #(.TURN_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v3), .req0_wr(1'b0), .req0_addr(a3), .req0_wdata(8'h00),
        .req0_ready(rdy3), .req0_rvalid(rv3), .req0_rdata(rdata3),
        .req1_valid(1'b0), .req1_wr(1'b0), .req1_addr(5'd0), .req1_wdata(8'h00),
        .req1_ready(n_ready3), .req1_rvalid(n_rvalid3), .req1_rdata(n_rdata3),
        .ram_io(io3), .ram_rd_wr(rd_wr3), .ram_s(s3),
        .ram_address(addr3), .ram_en(en3)
    );

    // RAM models: drive the bus when selected for read, store on selected write cycles.
    assign ram_drive = (ram_s == 2'b00) && ram_rd_wr;
    assign ram_en    = ram_drive || force_en;
    assign ram_io    = ram_drive ? mem[ram_address] : 8'hzz;
    assign drive3    = (s3 == 2'b00) && rd_wr3;
    assign en3       = drive3;
    assign io3       = drive3 ? mem3[addr3] : 8'hzz;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  <= 8'h00;
                mem3[i] <= 8'h00;
            end
            mem[31] <= 8'hFF;
            mem3[4] <= 8'h44;
            mem3[6] <= 8'h66;
        end else begin
            if (ram_s == 2'b00 && !ram_rd_wr) mem[ram_address] <= ram_io;
        end
    end

    int         rv3_cnt = 0;
    logic       rv3_prev = 1'b0;
    int         rv3_wide = 0;
    logic [7:0] rv3_data [0:1];
    always @(negedge clk) begin
        rv3_prev <= rv3;
        if (rv3) begin
            if (rv3_cnt < 2) rv3_data[rv3_cnt] <= rdata3;
            rv3_cnt <= rv3_cnt + 1;
            if (rv3_prev) rv3_wide <= rv3_wide + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic rdy_of(input int m);
        case (m)
            0:       return r0_ready;
            1:       return r1_ready;
            2:       return r0_ready | r1_ready;
            default: return rdy3;
        endcase
    endfunction

    task automatic wait_rdy(input int m, output int t);
        int k;
        k = 0;
        #1;
        while (rdy_of(m) !== 1'b1 && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("ready_timeout", (k < 20) ? 32'd1 : 32'd0, 32'd1);
        t = cyc;
    endtask

    initial begin
        int t0, t1, n;
        rst_n = 1'b0; preload = 1'b1; force_en = 1'b0;
        r0_valid = 1'b0; r0_wr = 1'b0; r0_addr = 5'd0; r0_wdata = 8'h00;
        r1_valid = 1'b0; r1_wr = 1'b0; r1_addr = 5'd0; r1_wdata = 8'h00;
        v3 = 1'b0; a3 = 5'd0;
        step(); step();
        preload = 1'b0;

        chk("rst_ram_s", ram_s, 2'b11);
        chk("rst_rd_wr", ram_rd_wr, 1'b1);
        chk("rst_addr", ram_address, 5'd0);
        chk("rst_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
        chk("rst_rdata", {r0_rdata, r1_rdata}, 16'h0000);
        chk("rst_ready", {r0_ready, r1_ready}, 2'b00);
        chk("rst_oe", dut.io_oe_s, 1'b0);
        chk("rst_last_grant", dut.last_grant_q, 1'b1);
        rst_n = 1'b1;
        step();

        // req0 write 5 <= A5 then read it back
        r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 5'd5; r0_wdata = 8'hA5;
        wait_rdy(0, t0);
        step(); r0_valid = 1'b0;
        chk("a_wr0_sel", ram_s, 2'b00);
        chk("a_wr0_rdwr", ram_rd_wr, 1'b0);
        chk("a_wr0_addr", ram_address, 5'd5);
        chk("a_wr0_oe", dut.io_oe_s, 1'b1);
        step();
        chk("a_wr1_sel", ram_s, 2'b00);
        chk("a_wr1_rdwr", ram_rd_wr, 1'b0);
        chk("a_wr1_io", ram_io, 8'hA5);
        step();
        chk("a_idle_sel", ram_s, 2'b11);
        chk("a_mem5", mem[5], 8'hA5);
        r0_valid = 1'b1; r0_wr = 1'b0;
        wait_rdy(0, t1);
        chk("a_wr_to_rd_gap", t1 - t0, 32'd3);
        step(); r0_valid = 1'b0;
        chk("a_rd0_sel", ram_s, 2'b00);
        chk("a_rd0_rdwr", ram_rd_wr, 1'b1);
        chk("a_rd0_oe", dut.io_oe_s, 1'b0);
        step();
        chk("a_rd1_rvalid", r0_rvalid, 1'b0);
        step();
        chk("a_rvalid0", r0_rvalid, 1'b1);
        chk("a_rdata0", r0_rdata, 8'hA5);
        chk("a_rvalid1", r1_rvalid, 1'b0);
        step();
        chk("a_rvalid0_pulse", r0_rvalid, 1'b0);
        chk("a_rdata0_hold", r0_rdata, 8'hA5);

        // both masters valid after reset: grants alternate starting with req0
        rst_n = 1'b0; step();
        chk("b_rst_last_grant", dut.last_grant_q, 1'b1);
        rst_n = 1'b1; step();
        r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 5'd1; r0_wdata = 8'h11;
        r1_valid = 1'b1; r1_wr = 1'b1; r1_addr = 5'd2; r1_wdata = 8'h22;
        for (int k = 0; k < 4; k++) begin
            wait_rdy(2, t1);
            chk("b_one_ready", {31'd0, r0_ready & r1_ready}, 32'd0);
            chk("b_grant", {31'd0, r1_ready}, k % 2);
            if (k > 0) chk("b_gap", t1 - t0, 32'd3);
            t0 = t1;
            step();
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        step(); step();
        chk("b_mem1", mem[1], 8'h11);
        chk("b_mem2", mem[2], 8'h22);

        // req1 read 31 with a write to 0 pending right behind it
        r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 5'd31;
        wait_rdy(1, t0);
        step();
        r1_wr = 1'b1; r1_addr = 5'd0; r1_wdata = 8'h5A;
        #1;
        chk("c_busy_ready", r1_ready, 1'b0);
        step();
        chk("c_rd1_oe", dut.io_oe_s, 1'b0);
        step();
        chk("c_rvalid1", r1_rvalid, 1'b1);
        chk("c_rdata1", r1_rdata, 8'hFF);
        chk("c_rvalid0", r0_rvalid, 1'b0);
        chk("c_turn_ready", r1_ready, 1'b0);
        chk("c_turn_bus", {dut.io_oe_s, ram_drive}, 2'b00);
        chk("c_turn_sel", ram_s, 2'b11);
        wait_rdy(1, t1);
        chk("c_wr_accept_gap", t1 - t0, 32'd4);
        step(); r1_valid = 1'b0;
        step(); step();
        chk("c_mem0", mem[0], 8'h5A);
        chk("c_no_conflict", dut.bus_conflict_q, 1'b0);
        chk("c_rdata1_hold", r1_rdata, 8'hFF);

        // req0 pulses valid for one cycle while the FSM sits in RD1
        r1_valid = 1'b1; r1_wr = 1'b0; r1_addr = 5'd2;
        wait_rdy(1, t0);
        step(); r1_valid = 1'b0;
        step();
        r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 5'd7; r0_wdata = 8'h77;
        #1;
        chk("d_no_ready", r0_ready, 1'b0);
        step(); r0_valid = 1'b0;
        chk("d_rvalid1", r1_rvalid, 1'b1);
        chk("d_rdata1", r1_rdata, 8'h22);
        chk("d_rvalid0", r0_rvalid, 1'b0);
        step();
        chk("d_last_grant", dut.last_grant_q, 1'b1);
        step(); step();
        chk("d_no_access", ram_s, 2'b11);
        chk("d_mem7", mem[7], 8'h00);

        // RAM still driving during a write sets the sticky conflict flag
        r0_valid = 1'b1; r0_wr = 1'b1; r0_addr = 5'd9; r0_wdata = 8'h99;
        wait_rdy(0, t0);
        force_en = 1'b1;
        step(); r0_valid = 1'b0;
        chk("f_oe_blocked", dut.io_oe_s, 1'b0);
        chk("f_wr0_sel", ram_s, 2'b00);
        step();
        chk("f_wr1_rdwr", ram_rd_wr, 1'b0);
        step(); force_en = 1'b0;
        chk("f_conflict", dut.bus_conflict_q, 1'b1);
        chk("f_done_sel", ram_s, 2'b11);
        step();
        chk("f_conflict_sticky", dut.bus_conflict_q, 1'b1);

        // reset asserted mid-RD1
        r0_valid = 1'b1; r0_wr = 1'b0; r0_addr = 5'd5;
        wait_rdy(0, t0);
        step(); r0_valid = 1'b0;
        step();
        chk("e_in_rd1", ram_s, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("e_rst_sel", ram_s, 2'b11);
        chk("e_rst_rdwr", ram_rd_wr, 1'b1);
        chk("e_rst_bus", {dut.io_oe_s, ram_drive}, 2'b00);
        chk("e_rst_ready", {r0_ready, r1_ready}, 2'b00);
        chk("e_rst_conflict", dut.bus_conflict_q, 1'b0);
        step(); rst_n = 1'b1;
        n = 0;
        repeat (4) begin
            step();
            n = n + int'(r0_rvalid) + int'(r1_rvalid);
        end
        chk("e_no_rvalid", n, 32'd0);

        // TURN_CYC=3: back-to-back reads by req0
        v3 = 1'b1; a3 = 5'd4;
        wait_rdy(3, t0);
        step(); a3 = 5'd6;
        wait_rdy(3, t1);
        chk("g_accept_gap", t1 - t0, 32'd6);
        step(); v3 = 1'b0;
        repeat (5) step();
        chk("g_rvalid_count", rv3_cnt, 32'd2);
        chk("g_rvalid_width", rv3_wide, 32'd0);
        chk("g_rdata_first", rv3_data[0], 8'h44);
        chk("g_rdata_second", rv3_data[1], 8'h66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
